// File: rtl/wb_stage_dual.sv
// Write-back stage: N-source result select, pipeline register, handshake,
// flush, and serialisation of dual-destination instructions into two writes.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   in_valid / in_ready         upstream handshake; in_ready is low in DUAL2
//   in_src_data, in_src_sel     flattened candidate results and their select
//   in_wr_en, in_rd             first write enable and destination
//   in_dual, in_rd2, in_data2   optional second destination and its data
//   flush                       synchronous kill of accepted/pending work
//   rf_we, rf_waddr, rf_wdata   registered register-file write port
//   sel_err                     one-cycle pulse for an out-of-range select
//   wb_count                    committed-write counter, wraps at 16 bits
module wb_stage_dual #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_SRC*DATA_W-1:0] in_src_data,
    input  logic [SEL_W-1:0]          in_src_sel,
    input  logic                      in_wr_en,
    input  logic [ADDR_W-1:0]         in_rd,
    input  logic                      in_dual,
    input  logic [ADDR_W-1:0]         in_rd2,
    input  logic [DATA_W-1:0]         in_data2,
    input  logic                      flush,
    output logic                      rf_we,
    output logic [ADDR_W-1:0]         rf_waddr,
    output logic [DATA_W-1:0]         rf_wdata,
    output logic                      sel_err,
    output logic [15:0]               wb_count
);

    typedef enum logic {
        IDLE,
        DUAL2
    } state_t;

    state_t              state_q, state_d;
    logic                rf_we_q, rf_we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                sel_err_q, sel_err_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [ADDR_W-1:0]   rd2_q, rd2_d;
    logic [DATA_W-1:0]   data2_q, data2_d;

    logic [DATA_W-1:0]   src_word;
    logic                sel_ok;
    logic                accept;

    // Out-of-range selects never index the bus; they fall back to zero.
    always_comb begin
        src_word = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (in_src_sel == SEL_W'(i)) begin
                src_word = in_src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign sel_ok   = (32'(in_src_sel) < NUM_SRC);
    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        rf_we_d   = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        sel_err_d = 1'b0;
        rd2_d     = rd2_q;
        data2_d   = data2_q;

        if (flush) begin
            // Flush beats both a new accept and the pending second write.
            state_d = IDLE;
            rd2_d   = '0;
            data2_d = '0;
        end else begin
            unique case (state_q)
                DUAL2: begin
                    rf_we_d = 1'b1;
                    waddr_d = rd2_q;
                    wdata_d = data2_q;
                    state_d = IDLE;
                end
                default: begin
                    if (accept) begin
                        if (!sel_ok) begin
                            sel_err_d = 1'b1;
                            wdata_d   = '0;
                        end else if (in_wr_en) begin
                            rf_we_d = 1'b1;
                            waddr_d = in_rd;
                            wdata_d = src_word;
                            if (in_dual) begin
                                rd2_d   = in_rd2;
                                data2_d = in_data2;
                                state_d = DUAL2;
                            end
                        end
                    end
                end
            endcase
        end

        cnt_d = cnt_q + 16'(rf_we_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rf_we_q   <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            sel_err_q <= 1'b0;
            cnt_q     <= '0;
            rd2_q     <= '0;
            data2_q   <= '0;
        end else begin
            state_q   <= state_d;
            rf_we_q   <= rf_we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            sel_err_q <= sel_err_d;
            cnt_q     <= cnt_d;
            rd2_q     <= rd2_d;
            data2_q   <= data2_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = waddr_q;
    assign rf_wdata = wdata_q;
    assign sel_err  = sel_err_q;
    assign wb_count = cnt_q;

endmodule

// File: tb/tb_wb_stage_dual.sv
// Scoreboard bench for wb_stage_dual: a 4-source instance for the main
// datapath and a 3-source instance for out-of-range select handling.
module tb_wb_stage_dual;

    typedef struct packed {
        logic        err;
        logic [2:0]  a;
        logic [15:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid, in_ready, wr_en, dual, flush;
    logic [63:0] src;
    logic [1:0]  sel;
    logic [2:0]  rd, rd2, rf_waddr;
    logic [15:0] data2, rf_wdata, wb_count;
    logic        rf_we, sel_err;

    logic        v3, rdy3, we3i, dual3, flush3;
    logic [47:0] src3;
    logic [1:0]  sel3;
    logic [2:0]  rd3, rd2_3, waddr3;
    logic [15:0] d2_3, wdata3, cnt3;
    logic        we3, err3;

    exp_t        q1[$];
    exp_t        q3[$];
    logic [15:0] rfm[8];
    int          total = 0;
    int          bad = 0;
    int          exp_cnt = 0;

    always #5 clk = ~clk;

    wb_stage_dual #(.DATA_W(16), .ADDR_W(3), .NUM_SRC(4), .SEL_W(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_src_data(src), .in_src_sel(sel),
        .in_wr_en(wr_en), .in_rd(rd),
        .in_dual(dual), .in_rd2(rd2), .in_data2(data2),
        .flush(flush),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .sel_err(sel_err), .wb_count(wb_count)
    );

    wb_stage_dual #(.DATA_W(16), .ADDR_W(3), .NUM_SRC(3), .SEL_W(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v3), .in_ready(rdy3),
        .in_src_data(src3), .in_src_sel(sel3),
        .in_wr_en(we3i), .in_rd(rd3),
        .in_dual(dual3), .in_rd2(rd2_3), .in_data2(d2_3),
        .flush(flush3),
        .rf_we(we3), .rf_waddr(waddr3), .rf_wdata(wdata3),
        .sel_err(err3), .wb_count(cnt3)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    task automatic mon1();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (rf_we || sel_err)) begin
                if (q1.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL mon1_unexpected: got we=%0b a=%0h d=%0h want none",
                             rf_we, rf_waddr, rf_wdata);
                end else begin
                    e = q1.pop_front();
                    chk("mon1_we", 32'(rf_we), 32'(!e.err));
                    chk("mon1_err", 32'(sel_err), 32'(e.err));
                    chk("mon1_data", 32'(rf_wdata), 32'(e.d));
                    if (!e.err) chk("mon1_addr", 32'(rf_waddr), 32'(e.a));
                end
                if (rf_we) rfm[rf_waddr] = rf_wdata;
            end
        end
    endtask

    task automatic mon3();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (we3 || err3)) begin
                if (q3.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL mon3_unexpected: got we=%0b err=%0b want none",
                             we3, err3);
                end else begin
                    e = q3.pop_front();
                    chk("mon3_we", 32'(we3), 32'(!e.err));
                    chk("mon3_err", 32'(err3), 32'(e.err));
                    chk("mon3_data", 32'(wdata3), 32'(e.d));
                    if (!e.err) chk("mon3_addr", 32'(waddr3), 32'(e.a));
                end
            end
        end
    endtask

    // Present a request, hold it until accepted, then post the expected writes.
    task automatic issue(input logic [1:0] s, input logic [15:0] d,
                         input logic w, input logic [2:0] r,
                         input logic du, input logic [2:0] r2,
                         input logic [15:0] d2, input logic push2);
        logic ok;
        src = {16'hBAD3, 16'hBAD2, 16'hBAD1, 16'hBAD0};
        src[int'(s)*16 +: 16] = d;
        sel = s; wr_en = w; rd = r; dual = du; rd2 = r2; data2 = d2;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("issue_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (w) begin
            q1.push_back('{err: 1'b0, a: r, d: d});
            exp_cnt++;
            if (du && push2) begin
                q1.push_back('{err: 1'b0, a: r2, d: d2});
                exp_cnt++;
            end
        end
    endtask

    task automatic drain();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 0; wr_en = 0; dual = 0; flush = 0;
        src = '0; sel = '0; rd = '0; rd2 = '0; data2 = '0;
        v3 = 0; we3i = 0; dual3 = 0; flush3 = 0;
        src3 = '0; sel3 = '0; rd3 = '0; rd2_3 = '0; d2_3 = '0;
        for (int i = 0; i < 8; i++) rfm[i] = '0;
        fork
            mon1();
            mon3();
        join_none

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_we", 32'(rf_we), 32'd0);
        chk("rst_addr", 32'(rf_waddr), 32'd0);
        chk("rst_data", 32'(rf_wdata), 32'd0);
        chk("rst_err", 32'(sel_err), 32'd0);
        chk("rst_cnt", 32'(wb_count), 32'd0);
        chk("rst_rdy", 32'(in_ready), 32'd1);

        // Out-of-range select on the 3-source instance, even with dual set.
        src3 = {16'h3333, 16'h2222, 16'h1111};
        sel3 = 2'd3; we3i = 1; rd3 = 3'd1; dual3 = 1; rd2_3 = 3'd2;
        d2_3 = 16'hEEEE; v3 = 1;
        q3.push_back('{err: 1'b1, a: 3'd0, d: 16'h0000});
        @(posedge clk);
        #1;
        v3 = 0;
        chk("sel3_err_pulse", 32'(err3), 32'd1);
        chk("sel3_we", 32'(we3), 32'd0);
        chk("sel3_rdy", 32'(rdy3), 32'd1);
        @(posedge clk);
        #1;
        chk("sel3_err_clear", 32'(err3), 32'd0);
        chk("sel3_no_dual2", 32'(we3), 32'd0);
        sel3 = 2'd2; rd3 = 3'd6; dual3 = 0; v3 = 1;
        q3.push_back('{err: 1'b0, a: 3'd6, d: 16'h3333});
        @(posedge clk);
        #1;
        v3 = 0;
        chk("sel3_cnt", 32'(cnt3), 32'd1);

        // Back-to-back singles.
        issue(2'd0, 16'h1111, 1, 3'd1, 0, 3'd0, 16'h0, 1);
        issue(2'd1, 16'h2222, 1, 3'd2, 0, 3'd0, 16'h0, 1);
        issue(2'd3, 16'h0F0F, 1, 3'd7, 0, 3'd0, 16'h0, 1);
        drain();
        chk("b2b_cnt", 32'(wb_count), 32'd3);
        chk("b2b_q_empty", 32'(q1.size()), 32'd0);

        // SWAP with a request queued behind it.
        issue(2'd0, 16'hAAAA, 1, 3'd3, 1, 3'd5, 16'h5555, 1);
        chk("swap_rdy_lo", 32'(in_ready), 32'd0);
        issue(2'd2, 16'h1234, 1, 3'd6, 0, 3'd0, 16'h0, 1);
        chk("swap_third_we", 32'(rf_we), 32'd1);
        chk("swap_third_addr", 32'(rf_waddr), 32'd6);
        drain();
        chk("swap_cnt", 32'(wb_count), 32'd6);

        // Bubble: wr_en=0 ignores dual.
        issue(2'd1, 16'h4444, 0, 3'd2, 1, 3'd3, 16'h4545, 1);
        chk("bubble_we", 32'(rf_we), 32'd0);
        chk("bubble_rdy", 32'(in_ready), 32'd1);
        chk("bubble_hold", 32'(rf_waddr), 32'd6);

        // Same destination twice; second write wins.
        issue(2'd2, 16'h0001, 1, 3'd4, 1, 3'd4, 16'h0002, 1);
        drain();
        chk("samedst_rf4", 32'(rfm[4]), 32'h0002);

        // Flush during DUAL2 kills the second write.
        issue(2'd0, 16'h7777, 1, 3'd1, 1, 3'd2, 16'h8888, 0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush2_we", 32'(rf_we), 32'd0);
        chk("flush2_rdy", 32'(in_ready), 32'd1);
        chk("flush2_cnt", 32'(wb_count), 32'(exp_cnt));

        // Flush coincident with a valid request drops it.
        sel = 2'd0; src = {48'h0, 16'h9999}; wr_en = 1; rd = 3'd7;
        dual = 0; in_valid = 1; flush = 1;
        @(negedge clk);
        chk("flushv_rdy", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 0; flush = 0;
        chk("flushv_we", 32'(rf_we), 32'd0);
        drain();
        chk("flushv_cnt", 32'(wb_count), 32'(exp_cnt));

        // Asynchronous reset while in DUAL2.
        issue(2'd0, 16'h4242, 1, 3'd1, 1, 3'd2, 16'h2424, 0);
        #5;
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        chk("arst_we", 32'(rf_we), 32'd0);
        chk("arst_cnt", 32'(wb_count), 32'd0);
        chk("arst_rdy", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drain();
        chk("arst_no_second", 32'(rf_we), 32'd0);
        chk("arst_cnt_after", 32'(wb_count), 32'd0);

        // Preload the counter to 0xFFFF, then wrap.
        for (int k = 0; k < 65535; k++) begin
            issue(2'(k), 16'(k), 1, 3'(k), 0, 3'd0, 16'h0, 1);
        end
        drain();
        chk("cnt_ffff", 32'(wb_count), 32'h0000FFFF);
        issue(2'd1, 16'hBEEF, 1, 3'd3, 0, 3'd0, 16'h0, 1);
        drain();
        chk("cnt_wrap", 32'(wb_count), 32'd0);

        chk("q1_empty", 32'(q1.size()), 32'd0);
        chk("q3_empty", 32'(q3.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
